// File: rtl/mem_boot_pkg.sv
// Shared constants for the power-up memory initialiser: FSM state encodings
// and the legal source-latency range.
package mem_boot_pkg;

  localparam int SRC_LAT_MIN = 1;
  localparam int SRC_LAT_MAX = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mem_boot_loader_if.sv
// Source-RAM read port and target-memory write port used by the boot loader.
interface mem_boot_loader_if #(
  parameter int AW  = 19,
  parameter int SAW = 16,
  parameter int DW  = 8
);

  logic [SAW-1:0] srcA;
  logic [DW-1:0]  srcQ;
  logic [AW-1:0]  dstA;
  logic [DW-1:0]  dstD;
  logic           dstWr;
  logic           dstAck;

  modport master (output srcA, input srcQ, output dstA, output dstD, output dstWr, input dstAck);
  modport slave  (input srcA, output srcQ, input dstA, input dstD, input dstWr, output dstAck);

endinterface

// File: rtl/mem_boot_loader.sv
// Copies a ROM image from the source RAM into the bottom of the target memory,
// fills the remainder with a constant, then hands the buses over via done.
module mem_boot_loader
  import mem_boot_pkg::*;
#(
  parameter int             AW          = 19,
  parameter int             SAW         = 16,
  parameter int             DW          = 8,
  parameter int             COPY_WORDS  = 65536,
  parameter int             TOTAL_WORDS = 524288,
  parameter logic [DW-1:0]  FILL        = '0,
  parameter int             SRC_LAT     = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ce,
  input  logic               ready,
  input  logic               restart,
  output logic               busy,
  output logic               done,
  mem_boot_loader_if.master  bus
);

  if (SRC_LAT < SRC_LAT_MIN || SRC_LAT > SRC_LAT_MAX) begin : g_bad_lat
    $error("mem_boot_loader: SRC_LAT out of range");
  end
  if (COPY_WORDS > TOTAL_WORDS || TOTAL_WORDS > (1 << AW) || COPY_WORDS > (1 << SAW)) begin : g_bad_size
    $error("mem_boot_loader: inconsistent COPY_WORDS/TOTAL_WORDS");
  end

  // Counter is one bit wider than the address so TOTAL_WORDS = 2^AW cannot wrap.
  localparam logic [AW:0] LAST_CNT = (AW+1)'(TOTAL_WORDS - 1);
  localparam logic [AW:0] COPY_CNT = (AW+1)'(COPY_WORDS);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [1:0]  LAT_END  = 2'(SRC_LAT);
  localparam bit          HAS_COPY = (COPY_WORDS > 0);

  logic [2:0]     state_q, state_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [1:0]     lat_q, lat_d;
  logic [SAW-1:0] src_a_q, src_a_d;
  logic [AW-1:0]  dst_a_q, dst_a_d;
  logic [DW-1:0]  dst_d_q, dst_d_d;
  logic           dst_wr_q, dst_wr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           restart_q, restart_d;
  logic           restart_rise;
  logic           acked;
  logic [AW:0]    cnt_inc;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    src_a_d      = src_a_q;
    dst_a_d      = dst_a_q;
    dst_d_d      = dst_d_q;
    dst_wr_d     = dst_wr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    restart_d    = ce ? restart : restart_q;
    restart_rise = ce & restart & ~restart_q;
    acked        = ~dst_wr_q | bus.dstAck;
    cnt_inc      = cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (ce && ready) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          lat_d  = '0;
          if (HAS_COPY) begin
            state_d = ST_READ;
            src_a_d = '0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_READ: begin
        // srcA was registered on entry, so data is ready one tick after SRC_LAT.
        if (ce) begin
          if (lat_q == LAT_END) begin
            dst_d_d  = bus.srcQ;
            dst_a_d  = cnt_q[AW-1:0];
            dst_wr_d = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
      end
      ST_FILL: begin
        if (ce) begin
          dst_d_d  = FILL;
          dst_a_d  = cnt_q[AW-1:0];
          dst_wr_d = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The ack may land on a non-ce clock; dropping dstWr records it.
        if (dst_wr_q && bus.dstAck) begin
          dst_wr_d = 1'b0;
        end
        if (ce && acked) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < COPY_CNT) begin
              state_d = ST_READ;
              src_a_d = cnt_inc[SAW-1:0];
              lat_d   = '0;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
      end
      ST_DONE: begin
        if (restart_rise) begin
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing the SDRAM mid-sequence aborts on any clock and restarts from word 0.
    if (!ready && (state_q == ST_READ || state_q == ST_FILL || state_q == ST_WRITE)) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      dst_wr_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      src_a_q   <= '0;
      dst_a_q   <= '0;
      dst_d_q   <= '0;
      dst_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      src_a_q   <= src_a_d;
      dst_a_q   <= dst_a_d;
      dst_d_q   <= dst_d_d;
      dst_wr_q  <= dst_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      restart_q <= restart_d;
    end
  end

  assign bus.srcA  = src_a_q;
  assign bus.dstA  = dst_a_q;
  assign bus.dstD  = dst_d_q;
  assign bus.dstWr = dst_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
- Power-up memory initialiser sitting between the dual-port video/ROM RAM and the SDRAM controller.
- After SDRAM reports ready, copies a ROM image from the source RAM into the low part of the target memory, then fills the rest with a constant.
- Asserts done, which the top level uses to hand memory buses over to the core.
- Generalises the original counter-based init: parametrised sizes, configurable source latency, an ack handshake instead of free-running write toggling, and on-demand re-initialisation.

Parameters:
- AW, 19, target address width (words).
- SAW, 16, source address width.
- DW, 8, data width.
- COPY_WORDS, 65536, words copied from source, starting at target address 0; must be ≤ 2^SAW and ≤ 2^AW.
- TOTAL_WORDS, 524288, total words initialised; must be ≥ COPY_WORDS and ≤ 2^AW.
- FILL, 8'h00, value written to addresses COPY_WORDS..TOTAL_WORDS-1.
- SRC_LAT, 1, source read latency in ce ticks (1..3).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; all state advances only when ce=1.
- ready  in  1  SDRAM controller initialised.
- restart  in  1  level, sampled on ce; a rising edge requests full re-initialisation.
- srcA  out  SAW  source RAM read address.
- srcQ  in  DW  source RAM read data, valid SRC_LAT ce ticks after srcA.
- dstA  out  AW  target write address.
- dstD  out  DW  target write data.
- dstWr  out  1  write request, active-high.
- dstAck  in  1  target accepted write (one-clock pulse, may arrive on any clock, qualified by dstWr).
- busy  out  1  initialisation in progress.
- done  out  1  initialisation complete; core owns memory.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; address counter 0.
  - srcA=0, dstA=0, dstD=0, dstWr=0, busy=0, done=0.
  - restart edge detector is cleared to 0.
- State machine (transitions on ce unless noted):
  - IDLE: when ready=1 -> busy=1, go to READ if COPY_WORDS>0, else FILL.
  - READ: srcA=cnt[SAW-1:0]. Wait exactly SRC_LAT ce ticks, then latch srcQ into dstD and go to WRITE.
  - FILL: dstD=FILL, go to WRITE.
  - WRITE:
    - dstA=cnt, dstWr=1. dstD is held stable while dstWr=1.
    - On dstAck (any clock, not ce-gated), clear dstWr on the next clock.
    - If cnt==TOTAL_WORDS-1 -> DONE. Otherwise cnt+1, then go to READ if cnt+1<COPY_WORDS, else FILL.
  - DONE: busy=0, done=1. Outputs hold last values, except dstWr=0.
- ready dropping to 0 during READ/FILL/WRITE:
  - Abort: dstWr=0 immediately on the next clock.
  - Return to IDLE with cnt reset to 0; the sequence restarts from the beginning when ready returns.
- restart:
  - Rising edge while in DONE -> done=0, cnt=0, go to IDLE.
  - Ignored while busy.
- Counter:
  - AW+1 bits wide so TOTAL_WORDS=2^AW causes no overflow.
  - The comparison uses the full-width counter.
- Timing:
  - Every target address is written exactly once per sequence, in ascending order.
  - No write is issued before ready=1.
  - Minimum cycle per word: (SRC_LAT+2) ce ticks for copy, 2 ce ticks for fill, plus ack wait.
- Simultaneous events: with dstAck and ready falling in the same clock, the abort wins. The word is considered written, but the restart from 0 rewrites it.

Decomposition:
- Shared package mem_boot_pkg holds:
  - state enum: IDLE, READ, FILL, WRITE, DONE.
  - SRC_LAT bounds check constants.
- Sub-module: none required.
  - The restart edge detector is small enough to stay inline.
  - The read-latency delay is a small counter inside the FSM, not a separate block.

Test Plan:
- Reset release, ready held 0 for 100 ce -> no dstWr, busy=0, done=0. Raise ready -> first dstWr within SRC_LAT+2 ce with dstA=0, dstD=src[0].
- COPY_WORDS=16, TOTAL_WORDS=32, source src[i]=i^8'hA5, dstAck 1 clock after each dstWr -> scoreboard shows dst[0..15]=src values, dst[16..31]=FILL, done=1 after the last ack, exactly 32 writes.
- dstAck delayed by random 0..20 clocks -> dstA/dstD stable while dstWr=1, no dropped or duplicated addresses.
- ready deasserted at word 10 of 32 -> dstWr=0 next clock. On ready reassert, writes restart at dstA=0; totals still complete to done=1.
- In DONE, pulse restart high for 3 ce -> one re-init only, done drops, full 32-word sequence repeats. A restart pulse issued mid-sequence is ignored.
- Sweep SRC_LAT=1,2,3, plus COPY_WORDS=0 and COPY_WORDS=TOTAL_WORDS -> correct data capture per latency, fill-only run, copy-only run, no source reads when COPY_WORDS=0.
